// File: rtl/psum_accum.sv
// psum_accum: accumulates signed partial sums from the compute unit in groups
// of acc_len, then emits one saturated PSUM_W-wide result per group until
// num_out results have been handed downstream.
// Optional build macro: PSUM_RELU_EN zeroes negative results after the clamp.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid and
// ready are both 1. The producer holds data stable while valid=1 and ready=0.
// psum_ready is 1 only in ACCUM. out_valid and out_data hold steady in DRAIN
// until out_ready=1.
module psum_accum #(
  parameter int PSUM_W = 32,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 8
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  acc_len,
  input  logic [LEN_W-1:0]  num_out,
  input  logic [PSUM_W-1:0] psum_in,
  input  logic              psum_valid,
  output logic              psum_ready,
  output logic [PSUM_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              sat_flag,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] ONE   = LEN_W'(1);
  localparam logic [ACC_W-1:0] MAX_V = {{(ACC_W-PSUM_W+1){1'b0}}, {(PSUM_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_V = {{(ACC_W-PSUM_W+1){1'b1}}, {(PSUM_W-1){1'b0}}};

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic [LEN_W-1:0]  psum_cnt, out_cnt, len_q, num_q;
  logic              psum_acc, out_acc, last_psum, last_out;
  logic [PSUM_W-1:0] clamp_val, res_val;
  logic              clamp_hit;

  assign psum_ready = (state == S_ACCUM);
  assign busy       = (state != S_IDLE);
  assign state_dbg  = state;

  // Counters count up from 0; comparing against len-1 makes a length of 0
  // naturally mean 2^LEN_W because the subtraction wraps.
  assign psum_acc  = (state == S_ACCUM) && psum_valid;
  assign out_acc   = (state == S_DRAIN) && out_ready;
  assign last_psum = (psum_cnt == len_q - ONE);
  assign last_out  = (out_cnt == num_q - ONE);

  // Sign-extend the incoming psum and add; clamp the running sum to PSUM_W.
  always_comb begin
    acc_sum   = acc + {{(ACC_W-PSUM_W){psum_in[PSUM_W-1]}}, psum_in};
    clamp_hit = 1'b0;
    clamp_val = acc_sum[PSUM_W-1:0];
    if ($signed(acc_sum) > $signed(MAX_V)) begin
      clamp_val = {1'b0, {(PSUM_W-1){1'b1}}};
      clamp_hit = 1'b1;
    end else if ($signed(acc_sum) < $signed(MIN_V)) begin
      clamp_val = {1'b1, {(PSUM_W-1){1'b0}}};
      clamp_hit = 1'b1;
    end
`ifdef PSUM_RELU_EN
    res_val = clamp_val[PSUM_W-1] ? '0 : clamp_val;
`else
    res_val = clamp_val;
`endif
  end

  // Next-state logic: job start, group complete, output accepted.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_ACCUM;
      S_ACCUM: if (psum_acc && last_psum) state_nxt = S_DRAIN;
      S_DRAIN: if (out_ready) state_nxt = last_out ? S_IDLE : S_ACCUM;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Datapath: job setup, accumulation, result capture and output release.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      psum_cnt  <= '0;
      out_cnt   <= '0;
      len_q     <= '0;
      num_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      sat_flag  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            len_q    <= acc_len;
            num_q    <= num_out;
            acc      <= '0;
            psum_cnt <= '0;
            out_cnt  <= '0;
            sat_flag <= 1'b0;
          end
        end
        S_ACCUM: begin
          if (psum_acc) begin
            acc      <= acc_sum;
            psum_cnt <= psum_cnt + ONE;
            if (last_psum) begin
              out_data  <= res_val;
              out_valid <= 1'b1;
              sat_flag  <= sat_flag | clamp_hit;
            end
          end
        end
        S_DRAIN: begin
          if (out_acc) begin
            out_valid <= 1'b0;
            if (last_out) begin
              done <= 1'b1;
            end else begin
              acc      <= '0;
              psum_cnt <= '0;
              out_cnt  <= out_cnt + ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accum.sv
// tb_psum_accum: directed job table, hand sequences for reset and length
// boundaries, and randomized jobs checked against an arithmetic model.
module tb_psum_accum;

  localparam int PSUM_W = 32;
  localparam int ACC_W  = 40;
  localparam int LEN_W  = 8;

  logic              clock = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  acc_len = '0;
  logic [LEN_W-1:0]  num_out = '0;
  logic [PSUM_W-1:0] psum_in = '0;
  logic              psum_valid = 1'b0;
  logic              psum_ready;
  logic [PSUM_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              done;
  logic              sat_flag;
  logic [1:0]        state_dbg;

  psum_accum #(.PSUM_W(PSUM_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clock(clock), .rst_n(rst_n), .start(start), .acc_len(acc_len),
    .num_out(num_out), .psum_in(psum_in), .psum_valid(psum_valid),
    .psum_ready(psum_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .sat_flag(sat_flag),
    .state_dbg(state_dbg)
  );

  // Clock
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  logic [PSUM_W-1:0] pq[$];
  logic [PSUM_W-1:0] exp_q[$];

  typedef struct {
    int                len;
    int                nout;
    int                stall;
    int                np;
    logic [PSUM_W-1:0] p[8];
    int                exp_n;
    logic [PSUM_W-1:0] e[4];
    bit                exp_sat;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Reference: sum each group with wide arithmetic, saturate to 32 bits.
  function automatic logic [PSUM_W-1:0] clamp_model(input longint s_in, output bit hit);
    longint s;
    s   = s_in;
    hit = 1'b0;
    if (s > 64'sd2147483647) begin
      s = 64'sd2147483647; hit = 1'b1;
    end else if (s < -64'sd2147483648) begin
      s = -64'sd2147483648; hit = 1'b1;
    end
`ifdef PSUM_RELU_EN
    if (s < 0) s = 0;
`endif
    return s[31:0];
  endfunction

  task automatic build_expect(input int len, input int nout, output bit sat);
    int     len_e;
    int     nout_e;
    longint sum;
    bit     hit;
    len_e  = (len == 0) ? 256 : len;
    nout_e = (nout == 0) ? 256 : nout;
    sat    = 1'b0;
    exp_q.delete();
    for (int k = 0; k < nout_e; k++) begin
      sum = 0;
      for (int i = 0; i < len_e; i++) sum += longint'($signed(pq[k*len_e + i]));
      exp_q.push_back(clamp_model(sum, hit));
      sat |= hit;
    end
  endtask

  // Driver + monitor for one job. Entered and left at posedge+1.
  task automatic run_job(input int len, input int nout, input int stall,
                         input int gap, input int mid_start, input bit exp_sat);
    int len_e;
    int nout_e;
    int idx  = 0;
    int outs = 0;
    int vcnt = 0;
    int cyc  = 0;
    bit exp_vnext = 1'b0;
    len_e  = (len == 0) ? 256 : len;
    nout_e = (nout == 0) ? 256 : nout;
    start = 1'b1; acc_len = LEN_W'(len); num_out = LEN_W'(nout);
    psum_valid = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    check("busy_before_start", busy, 0);
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    check("busy_after_start", busy, 1);
    check("ready_in_accum", psum_ready, 1);
    @(posedge clock); #1;
    while (outs < nout_e && cyc < 6000) begin
      psum_valid = (idx < pq.size()) && (gap == 0 || $urandom_range(0, gap) == 0);
      psum_in    = (idx < pq.size()) ? pq[idx] : $urandom;
      out_ready  = out_valid ? (vcnt >= stall) : 1'($urandom_range(0, 1));
      start      = (mid_start != 0) && (cyc == mid_start);
      acc_len    = start ? LEN_W'(3) : LEN_W'(len);
      @(negedge clock);
      if (exp_vnext) begin
        check("valid_latency", out_valid, 1);
        exp_vnext = 1'b0;
      end
      if (psum_valid && psum_ready) begin
        idx++;
        if (idx % len_e == 0) exp_vnext = 1'b1;
      end
      if (out_valid) begin
        check("ready_in_drain", psum_ready, 0);
        if (exp_q.size() == 0) check("extra_output", 1, 0);
        else                   check("out_data", out_data, exp_q[0]);
        if (out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          outs++;
          vcnt = 0;
        end else begin
          vcnt++;
        end
      end
      check("no_early_done", done, 0);
      @(posedge clock); #1;
      cyc++;
    end
    if (cyc >= 6000) check("job_timeout", 1, 0);
    psum_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
    @(negedge clock);
    check("done_pulse", done, 1);
    check("busy_end", busy, 0);
    check("ready_idle", psum_ready, 0);
    check("sat_flag", sat_flag, exp_sat);
    check("psums_consumed", idx, pq.size());
    @(negedge clock);
    check("done_one_cycle", done, 0);
    @(posedge clock); #1;
  endtask

  initial begin
    bit sat;
    int len;
    int nout;

    // Directed job table.
    tbl[0].len = 4; tbl[0].nout = 1; tbl[0].stall = 0; tbl[0].np = 4;
    tbl[0].p[0] = 16; tbl[0].p[1] = 32; tbl[0].p[2] = -25; tbl[0].p[3] = 255;
    tbl[0].exp_n = 1; tbl[0].e[0] = 278; tbl[0].exp_sat = 1'b0;

    tbl[1].len = 2; tbl[1].nout = 3; tbl[1].stall = 5; tbl[1].np = 6;
    for (int i = 0; i < 6; i++) tbl[1].p[i] = PSUM_W'(i + 1);
    tbl[1].exp_n = 3; tbl[1].e[0] = 3; tbl[1].e[1] = 7; tbl[1].e[2] = 11;
    tbl[1].exp_sat = 1'b0;

    tbl[2].len = 2; tbl[2].nout = 2; tbl[2].stall = 0; tbl[2].np = 4;
    tbl[2].p[0] = 32'h7FFF_FFFF; tbl[2].p[1] = 32'h7FFF_FFFF;
    tbl[2].p[2] = -256; tbl[2].p[3] = -1024;
    tbl[2].exp_n = 2; tbl[2].e[0] = 32'h7FFF_FFFF;
`ifdef PSUM_RELU_EN
    tbl[2].e[1] = 0;
`else
    tbl[2].e[1] = -1280;
`endif
    tbl[2].exp_sat = 1'b1;

    tbl[3].len = 2; tbl[3].nout = 1; tbl[3].stall = 1; tbl[3].np = 2;
    tbl[3].p[0] = 32'h8000_0000; tbl[3].p[1] = 32'h8000_0000;
    tbl[3].exp_n = 1;
`ifdef PSUM_RELU_EN
    tbl[3].e[0] = 0;
`else
    tbl[3].e[0] = 32'h8000_0000;
`endif
    tbl[3].exp_sat = 1'b1;

    // Reset state.
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_psum_ready", psum_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_out_data", out_data, 0);
    @(posedge clock); #1;
    rst_n = 1'b1;
    @(posedge clock); #1;

    foreach (tbl[t]) begin
      pq.delete();
      exp_q.delete();
      for (int i = 0; i < tbl[t].np; i++) pq.push_back(tbl[t].p[i]);
      for (int i = 0; i < tbl[t].exp_n; i++) exp_q.push_back(tbl[t].e[i]);
      run_job(tbl[t].len, tbl[t].nout, tbl[t].stall, (t == 1) ? 2 : 0, 0, tbl[t].exp_sat);
    end

    // Leave a nonzero result on out_data, then reset mid-job.
    pq = '{32'd10, 32'd20, 32'd30};
    exp_q = '{32'd60};
    run_job(3, 1, 0, 0, 0, 1'b0);
    start = 1'b1; acc_len = 4; num_out = 1;
    @(posedge clock); #1;
    start = 1'b0; psum_valid = 1'b1; psum_in = 100;
    @(posedge clock); #1;
    psum_in = 200;
    @(posedge clock); #1;
    psum_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_psum_ready", psum_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_sat_flag", sat_flag, 0);
    @(posedge clock); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("postrst_no_done", done, 0);
      check("postrst_idle", busy, 0);
    end
    @(posedge clock); #1;
    pq = '{32'd5};
    exp_q = '{32'd5};
    run_job(1, 1, 0, 0, 0, 1'b0);

    // acc_len = 0 means 256 psums; a start pulse mid-job must be ignored.
    pq.delete();
    for (int i = 0; i < 256; i++) pq.push_back(32'd1);
    exp_q = '{32'd256};
    run_job(0, 1, 0, 1, 20, 1'b0);

    // num_out = 0 means 256 outputs.
    pq.delete();
    for (int i = 0; i < 256; i++) pq.push_back(PSUM_W'($urandom_range(0, 2000)) - 32'd1000);
    build_expect(1, 0, sat);
    run_job(1, 0, 0, 1, 0, sat);

    // Randomized jobs against the arithmetic model.
    for (int j = 0; j < 20; j++) begin
      len  = $urandom_range(1, 8);
      nout = $urandom_range(1, 3);
      pq.delete();
      for (int i = 0; i < len * nout; i++) begin
        if ($urandom_range(0, 3) == 0) pq.push_back($urandom);
        else pq.push_back(PSUM_W'($urandom_range(0, 2000)) - 32'd1000);
      end
      build_expect(len, nout, sat);
      run_job(len, nout, $urandom_range(0, 3), 2, (j % 4 == 0) ? 3 : 0, sat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/psum_accum.md
PSUM_ACCUM -- requirements
Module: psum_accum

Interface
REQ-001 The block SHALL have parameter PSUM_W, default 32, meaning the compute-unit partial-sum width.
REQ-002 The block SHALL have parameter ACC_W, default 40, meaning the internal signed accumulator width.
REQ-003 The block SHALL have parameter LEN_W, default 8, meaning the width of the length and count fields.
REQ-004 The block SHALL have ports: clock  in  1  rising-edge clock.
REQ-005 The block SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-006 The block SHALL have ports: start  in  1  one-cycle job start pulse.
REQ-007 The block SHALL have ports: acc_len  in  LEN_W  psums per output (0 means 2^LEN_W).
REQ-008 The block SHALL have ports: num_out  in  LEN_W  outputs per job (0 means 2^LEN_W).
REQ-009 The block SHALL have ports: psum_in  in  PSUM_W  signed partial sum from cmp_unit psum_out.
REQ-010 The block SHALL have ports: psum_valid  in  1  psum_in valid.
REQ-011 The block SHALL have ports: psum_ready  out  1  block accepts psum_in.
REQ-012 The block SHALL have ports: out_data  out  PSUM_W  signed saturated accumulated result.
REQ-013 The block SHALL have ports: out_valid  out  1  out_data valid.
REQ-014 The block SHALL have ports: out_ready  in  1  downstream accepts out_data.
REQ-015 The block SHALL have ports: busy  out  1  job in progress.
REQ-016 The block SHALL have ports: done  out  1  one-cycle pulse after the last output is accepted.
REQ-017 The block SHALL have ports: sat_flag  out  1  sticky; set when any output of the current job was clamped.

Function
REQ-018 States SHALL be IDLE, ACCUM and DRAIN, encoded in a registered FSM.
REQ-019 IDLE with start=1 SHALL latch acc_len and num_out, clear the accumulator, psum counter, output counter and sat_flag, then enter ACCUM on the next edge.
REQ-020 start SHALL be ignored outside IDLE.
REQ-021 In ACCUM, psum_ready SHALL be 1; a psum is accepted on an edge where psum_valid and psum_ready are both 1.
REQ-022 Each accepted psum SHALL be sign-extended to ACC_W and added to the accumulator (wrap-free for up to 256 max-magnitude psums).
REQ-023 Acceptance of the latched-acc_len-th psum SHALL register the final sum into out_data, set out_valid and enter DRAIN on that same edge, so out_valid is visible in the cycle after the last psum.
REQ-024 out_data SHALL be the accumulator clamped to [-2^(PSUM_W-1), 2^(PSUM_W-1)-1]; any clamp SHALL set sat_flag.
REQ-025 In DRAIN, psum_ready SHALL be 0, and out_data and out_valid SHALL be held stable until out_ready=1.
REQ-026 On an accepted output that is not the last of the job, the block SHALL clear the accumulator and psum counter and return to ACCUM.
REQ-027 On the last accepted output, the block SHALL pulse done for one cycle and return to IDLE.
REQ-028 busy SHALL be 1 in ACCUM and DRAIN and 0 in IDLE.
REQ-029 psum_valid in IDLE or DRAIN SHALL be ignored, with no accumulation.
REQ-030 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-031 rst_n=0 SHALL asynchronously force state IDLE, the accumulator, the counters and out_data to 0, and out_valid, psum_ready, busy, done and sat_flag to 0.
REQ-032 Reset asserted mid-job SHALL discard all partial results; no done pulse SHALL follow.
REQ-033 After reset release, the block SHALL wait in IDLE for start.

Configuration
REQ-034 With macro PSUM_RELU_EN defined, negative clamped results SHALL be output as 0; sat_flag SHALL be unaffected by this ReLU zeroing.
REQ-035 Without PSUM_RELU_EN, signed clamped results SHALL pass unchanged.

Verification
REQ-036 start with acc_len=4, num_out=1 and psums 16, 32, -25, 255 with always-ready output -> out_data=278 one cycle after the 4th psum, then done, and busy falls.
REQ-037 acc_len=2, num_out=3, psums 1..6, out_ready held low 5 cycles per output -> outputs 3, 7, 11, out_data stable during stalls, psum_ready=0 in DRAIN.
REQ-038 acc_len=2, psums 0x7FFFFFFF, 0x7FFFFFFF -> out_data=0x7FFFFFFF and sat_flag=1; psums -256, -1024 -> out_data=-1280 (0 with PSUM_RELU_EN).
REQ-039 Assert rst_n=0 after the 2nd of 4 psums -> all outputs 0 immediately; a new job with acc_len=1 and psum 5 -> out_data=5.
REQ-040 acc_len=0 with 256 psums of value 1 -> single out_data=256; start pulsed during ACCUM -> ignored, and the count is unchanged.
